// File: rtl/range_tracker_pkg.sv
// Shared types for the framed min/max/range statistics engine.
package range_tracker_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DONE   = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        MODE_RANGE = 2'd0,
        MODE_MAX   = 2'd1,
        MODE_MIN   = 2'd2,
        MODE_COUNT = 2'd3
    } mode_t;

endpackage

// File: rtl/range_tracker_minmax_acc.sv
// Running max/min accumulator with frame clear and per-sample fold.
// The *_next outputs give the values including this cycle's sample.
module minmax_acc #(
    parameter int WIDTH = 10
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             fold,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] max_r,
    output logic [WIDTH-1:0] min_r,
    output logic [WIDTH-1:0] max_next,
    output logic [WIDTH-1:0] min_next
);

    logic [WIDTH-1:0] max_base;
    logic [WIDTH-1:0] min_base;

    // Clear and fold in the same cycle: the first sample of the new frame
    // is folded against the cleared values, not the stale ones.
    always_comb begin
        max_base = clear ? '0 : max_r;
        min_base = clear ? '1 : min_r;
        max_next = max_base;
        min_next = min_base;
        if (fold && (data_in > max_base)) max_next = data_in;
        if (fold && (data_in < min_base)) min_next = data_in;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            max_r <= '0;
            min_r <= '1;
        end else if (clear || fold) begin
            max_r <= max_next;
            min_r <= min_next;
        end
    end

endmodule

// File: rtl/range_tracker.sv
// Framed min/max/range statistics engine: go opens a frame, finish closes it
// and presents one registered result with a single-cycle valid pulse.
module range_tracker
    import range_tracker_pkg::*;
#(
    parameter int WIDTH = 10,
    parameter int CNT_W = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             go,
    input  logic             finish,
    input  logic             valid,
    input  logic [WIDTH-1:0] data_in,
    input  logic [1:0]       mode,
    input  logic             clr_err,
    output logic [WIDTH-1:0] result,
    output logic             result_valid,
    output logic             busy,
    output logic             error,
    output logic [CNT_W-1:0] sample_count
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next, cnt_base;
    logic [WIDTH-1:0] result_reg, result_next;
    logic             error_reg;
    logic             acc_clear, acc_fold, latch, err_set;
    logic [WIDTH-1:0] max_r, min_r, max_next, min_next;
    logic [WIDTH-1:0] cnt_as_result;

    minmax_acc #(.WIDTH(WIDTH)) u_acc (
        .clock    (clock),
        .reset    (reset),
        .clear    (acc_clear),
        .fold     (acc_fold),
        .data_in  (data_in),
        .max_r    (max_r),
        .min_r    (min_r),
        .max_next (max_next),
        .min_next (min_next)
    );

    generate
        if (CNT_W >= WIDTH) begin : g_cnt_trunc
            assign cnt_as_result = cnt_next[WIDTH-1:0];
        end else begin : g_cnt_ext
            assign cnt_as_result = {{(WIDTH-CNT_W){1'b0}}, cnt_next};
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        acc_clear  = 1'b0;
        acc_fold   = 1'b0;
        latch      = 1'b0;
        err_set    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (go && !finish) begin
                    state_next = ACTIVE;
                    acc_clear  = 1'b1;
                    acc_fold   = valid;
                end else if (finish) begin
                    err_set = 1'b1;
                end
            end
            ACTIVE: begin
                // The sample folds in every ACTIVE cycle, including the
                // finish cycle and a rejected go+finish cycle.
                acc_fold = valid;
                if (go && finish) begin
                    err_set = 1'b1;
                end else if (go) begin
                    err_set   = 1'b1;
                    acc_clear = 1'b1;
                end else if (finish) begin
                    latch      = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
                if (finish) err_set = 1'b1;
            end
            default: state_next = IDLE;
        endcase

        cnt_base = acc_clear ? '0 : cnt_reg;
        cnt_next = (acc_fold && (cnt_base != CNT_MAX)) ? cnt_base + 1'b1 : cnt_base;

        result_next = result_reg;
        if (latch) begin
            if (cnt_next == '0) begin
                result_next = '0;
                err_set     = 1'b1;
            end else begin
                case (mode_t'(mode))
                    MODE_RANGE: result_next = max_next - min_next;
                    MODE_MAX:   result_next = max_next;
                    MODE_MIN:   result_next = min_next;
                    MODE_COUNT: result_next = cnt_as_result;
                    default:    result_next = '0;
                endcase
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg  <= IDLE;
            cnt_reg    <= '0;
            result_reg <= '0;
            error_reg  <= 1'b0;
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            result_reg <= result_next;
            if (err_set)      error_reg <= 1'b1;
            else if (clr_err) error_reg <= 1'b0;
        end
    end

    assign result       = result_reg;
    assign result_valid = (state_reg == DONE);
    assign busy         = (state_reg == ACTIVE);
    assign error        = error_reg;
    assign sample_count = cnt_reg;

endmodule

// File: tb/tb_range_tracker.sv
// Bench for range_tracker: frame-level reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_range_tracker;

    localparam int WIDTH = 10;
    localparam int CNT_W = 3;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic             clock = 1'b0;
    logic             reset;
    logic             go, finish, valid, clr_err;
    logic [WIDTH-1:0] data_in;
    logic [1:0]       mode;
    logic [WIDTH-1:0] result;
    logic             result_valid, busy, error;
    logic [CNT_W-1:0] sample_count;

    range_tracker #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clock        (clock),
        .reset        (reset),
        .go           (go),
        .finish       (finish),
        .valid        (valid),
        .data_in      (data_in),
        .mode         (mode),
        .clr_err      (clr_err),
        .result       (result),
        .result_valid (result_valid),
        .busy         (busy),
        .error        (error),
        .sample_count (sample_count)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;
    bit check_en = 1'b0;

    // Model: protocol phase (0 idle, 1 in frame, 2 result cycle) plus the
    // list of samples collected in the current frame.
    int m_state;
    int m_samples[$];
    int m_cnt, m_result, m_err;
    int fq[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_state = 0;
        m_samples.delete();
        m_cnt = 0;
        m_result = 0;
        m_err = 0;
    endfunction

    function automatic void add_sample();
        m_samples.push_back(int'(data_in));
        if (m_cnt < CMAX) m_cnt++;
    endfunction

    function automatic void start_frame();
        m_samples.delete();
        m_cnt = 0;
        if (valid) add_sample();
    endfunction

    function automatic void model_step();
        bit set = 1'b0;
        int mx, mn;
        case (m_state)
            0: begin
                if (go && !finish) begin
                    start_frame();
                    m_state = 1;
                end else if (finish) set = 1'b1;
            end
            1: begin
                if (go && !finish) begin
                    set = 1'b1;
                    start_frame();
                end else begin
                    if (go) set = 1'b1;
                    if (valid) add_sample();
                    if (finish && !go) begin
                        m_state = 2;
                        if (m_samples.size() == 0) begin
                            m_result = 0;
                            set = 1'b1;
                        end else begin
                            mx = 0;
                            mn = (1 << WIDTH) - 1;
                            foreach (m_samples[i]) begin
                                if (m_samples[i] > mx) mx = m_samples[i];
                                if (m_samples[i] < mn) mn = m_samples[i];
                            end
                            case (mode)
                                2'd0: m_result = mx - mn;
                                2'd1: m_result = mx;
                                2'd2: m_result = mn;
                                default: m_result = m_cnt % (1 << WIDTH);
                            endcase
                        end
                    end
                end
            end
            default: begin
                if (finish) set = 1'b1;
                m_state = 0;
            end
        endcase
        if (set) m_err = 1;
        else if (clr_err) m_err = 0;
    endfunction

    always @(negedge clock) begin
        if (check_en) begin
            chk("busy", {31'd0, busy}, (m_state == 1) ? 32'd1 : 32'd0);
            chk("result_valid", {31'd0, result_valid}, (m_state == 2) ? 32'd1 : 32'd0);
            chk("result", {22'd0, result}, m_result);
            chk("error", {31'd0, error}, m_err);
            chk("sample_count", {29'd0, sample_count}, m_cnt);
        end
    end

    task automatic tick();
        @(posedge clock);
        if (reset) model_step();
        else model_reset();
        @(negedge clock);
    endtask

    task automatic drv(input logic g, input logic f, input logic v, input int d,
                       input logic [1:0] m, input logic c);
        go = g; finish = f; valid = v; data_in = d[WIDTH-1:0]; mode = m; clr_err = c;
        tick();
    endtask

    task automatic idle(input logic c);
        drv(0, 0, 0, 0, 0, c);
    endtask

    task automatic frame(input logic [1:0] md, input logic fv, input int fd);
        drv(1, 0, 0, 0, 0, 0);
        foreach (fq[i]) drv(0, 0, 1, fq[i], 0, 0);
        drv(0, 1, fv, fd, md, 0);
    endtask

    int exp_modes[3] = '{1023, 12, 4};

    initial begin
        reset = 1'b0;
        go = 0; finish = 0; valid = 0; data_in = '0; mode = '0; clr_err = 0;
        model_reset();
        repeat (2) @(negedge clock);
        chk("reset_result", {22'd0, result}, 0);
        chk("reset_busy", {31'd0, busy}, 0);
        chk("reset_error", {31'd0, error}, 0);
        chk("reset_count", {29'd0, sample_count}, 0);
        reset = 1'b1;
        check_en = 1'b1;

        // Basic range frame
        fq = '{300, 12, 1023, 500};
        frame(2'd0, 1'b0, 0);
        chk("range_result", {22'd0, result}, 1011);
        chk("range_rv", {31'd0, result_valid}, 1);
        chk("range_count", {29'd0, sample_count}, 4);
        chk("range_error", {31'd0, error}, 0);
        idle(0);
        chk("rv_drop", {31'd0, result_valid}, 0);
        chk("result_hold", {22'd0, result}, 1011);

        for (int md = 1; md <= 3; md++) begin
            frame(md[1:0], 1'b0, 0);
            chk("mode_sweep", {22'd0, result}, exp_modes[md-1]);
            idle(0);
        end

        fq = '{300, 1023};
        frame(2'd2, 1'b1, 5);
        chk("finish_sample_min", {22'd0, result}, 5);
        chk("finish_sample_cnt", {29'd0, sample_count}, 3);
        idle(0);

        // Empty frame
        fq.delete();
        frame(2'd1, 1'b0, 0);
        chk("empty_result", {22'd0, result}, 0);
        chk("empty_error", {31'd0, error}, 1);
        idle(1);
        chk("clr_err", {31'd0, error}, 0);

        drv(0, 1, 0, 0, 0, 0);
        chk("idle_finish_err", {31'd0, error}, 1);
        chk("idle_finish_busy", {31'd0, busy}, 0);
        idle(1);

        // go+finish together inside a frame
        drv(1, 0, 0, 0, 0, 0);
        drv(0, 0, 1, 8, 0, 0);
        drv(1, 1, 1, 20, 0, 0);
        chk("gofin_err", {31'd0, error}, 1);
        chk("gofin_busy", {31'd0, busy}, 1);
        drv(0, 1, 0, 0, 2'd1, 0);
        chk("gofin_result", {22'd0, result}, 20);
        chk("gofin_count", {29'd0, sample_count}, 2);
        idle(1);

        // Restart mid-frame
        drv(1, 0, 0, 0, 0, 0);
        drv(0, 0, 1, 7, 0, 0);
        drv(0, 0, 1, 9, 0, 0);
        drv(1, 0, 0, 0, 0, 0);
        chk("restart_count", {29'd0, sample_count}, 0);
        chk("restart_err", {31'd0, error}, 1);
        drv(0, 0, 1, 3, 0, 0);
        drv(0, 1, 0, 0, 2'd0, 0);
        chk("restart_result", {22'd0, result}, 0);
        chk("restart_cnt1", {29'd0, sample_count}, 1);
        idle(1);

        // Counter saturation
        fq.delete();
        for (int i = 0; i < 10; i++) fq.push_back(i * 50 + 1);
        frame(2'd3, 1'b0, 0);
        chk("sat_count", {29'd0, sample_count}, 7);
        chk("sat_result", {22'd0, result}, 7);
        chk("sat_error", {31'd0, error}, 0);
        idle(0);
        chk("sat_hold", {29'd0, sample_count}, 7);

        // Asynchronous reset in the middle of a frame
        drv(1, 0, 0, 0, 0, 0);
        drv(1, 1, 1, 50, 0, 0);
        drv(0, 0, 1, 60, 0, 0);
        #2 reset = 1'b0;
        #1;
        chk("arst_busy", {31'd0, busy}, 0);
        chk("arst_result", {22'd0, result}, 0);
        chk("arst_error", {31'd0, error}, 0);
        chk("arst_count", {29'd0, sample_count}, 0);
        model_reset();
        #1 reset = 1'b1;
        fq = '{4, 6};
        frame(2'd0, 1'b0, 0);
        chk("post_reset_range", {22'd0, result}, 2);
        idle(1);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            int d;
            case ($urandom_range(0, 5))
                0: d = 0;
                1: d = (1 << WIDTH) - 1;
                default: d = int'($urandom_range(0, (1 << WIDTH) - 1));
            endcase
            drv(($urandom_range(0, 7) == 0), ($urandom_range(0, 5) == 0),
                ($urandom_range(0, 2) != 0), d, 2'($urandom_range(0, 3)),
                ($urandom_range(0, 9) == 0));
        end

        check_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
